// File: rtl/pcpi_nibble_sequencer.sv
// Nibble-lane front end for a PCPI coprocessor: loads an instruction nibble by nibble,
// issues it with a bounded response time, and streams the captured result back out.
module pcpi_nibble_sequencer #(
  parameter int NIBBLES = 8,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  input  logic                 nib_valid,
  input  logic [3:0]           nib_data,
  output logic                 nib_ready,
  output logic                 pcpi_valid,
  output logic [4*NIBBLES-1:0] pcpi_insn,
  input  logic                 pcpi_ready,
  input  logic                 pcpi_wait,
  input  logic                 pcpi_wr,
  input  logic [4*NIBBLES-1:0] pcpi_rd,
  output logic                 res_valid,
  output logic [3:0]           res_nib,
  input  logic                 res_ready,
  output logic                 done,
  output logic                 err_timeout,
  output logic [1:0]           dbg_state
);

  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Handshakes: a nibble moves on nib_valid & nib_ready, a result nibble moves on
  // res_valid & res_ready; both sides hold data stable until the transfer edge.
  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_ISSUE  = 2'd1,
    S_UNLOAD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [W-1:0]       rd_q, rd_d;
  logic [W-1:0]       insn_d;
  logic               nib_ready_d, pcpi_valid_d, res_valid_d, done_d, err_d;
  logic [3:0]         res_nib_d;
  logic               cnt_last, timer_expire;

  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign cnt_last     = (cnt_q == CNT_W'(NIBBLES - 1));
  assign timer_expire = (timer_q == TMR_W'(TIMEOUT - 1));
  assign dbg_state    = state_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    rd_d         = rd_q;
    insn_d       = pcpi_insn;
    nib_ready_d  = nib_ready;
    pcpi_valid_d = pcpi_valid;
    res_valid_d  = res_valid;
    res_nib_d    = res_nib;
    done_d       = 1'b0;
    err_d        = err_timeout;

    if (abort) begin
      state_d      = S_LOAD;
      cnt_d        = '0;
      timer_d      = '0;
      pcpi_valid_d = 1'b0;
      res_valid_d  = 1'b0;
      nib_ready_d  = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          nib_ready_d = 1'b1;
          if (nib_valid && nib_ready) begin
            insn_d[4*cnt_q +: 4] = nib_data;
            err_d                = 1'b0;
            if (cnt_last) begin
              cnt_d        = '0;
              timer_d      = '0;
              nib_ready_d  = 1'b0;
              pcpi_valid_d = 1'b1;
              state_d      = S_ISSUE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        S_ISSUE: begin
          // A response in the expiry cycle still counts as a response.
          if (pcpi_ready) begin
            pcpi_valid_d = 1'b0;
            timer_d      = '0;
            if (pcpi_wr) begin
              rd_d        = pcpi_rd;
              res_nib_d   = pcpi_rd[3:0];
              res_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = S_UNLOAD;
            end else begin
              done_d      = 1'b1;
              nib_ready_d = 1'b1;
              state_d     = S_LOAD;
            end
          end else if (pcpi_wait) begin
            timer_d = '0;
          end else if (timer_expire) begin
            timer_d      = '0;
            pcpi_valid_d = 1'b0;
            err_d        = 1'b1;
            nib_ready_d  = 1'b1;
            state_d      = S_LOAD;
          end else if (timer_q != '1) begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        S_UNLOAD: begin
          if (res_ready) begin
            if (cnt_last) begin
              cnt_d       = '0;
              res_valid_d = 1'b0;
              done_d      = 1'b1;
              nib_ready_d = 1'b1;
              state_d     = S_LOAD;
            end else begin
              cnt_d     = cnt_inc;
              res_nib_d = rd_q[4*cnt_inc +: 4];
            end
          end
        end
        default: begin
          state_d      = S_LOAD;
          cnt_d        = '0;
          timer_d      = '0;
          pcpi_valid_d = 1'b0;
          res_valid_d  = 1'b0;
          nib_ready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      timer_q     <= '0;
      rd_q        <= '0;
      pcpi_insn   <= '0;
      nib_ready   <= 1'b0;
      pcpi_valid  <= 1'b0;
      res_valid   <= 1'b0;
      res_nib     <= 4'h0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      rd_q        <= rd_d;
      pcpi_insn   <= insn_d;
      nib_ready   <= nib_ready_d;
      pcpi_valid  <= pcpi_valid_d;
      res_valid   <= res_valid_d;
      res_nib     <= res_nib_d;
      done        <= done_d;
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_pcpi_nibble_sequencer.sv
// Directed bench for pcpi_nibble_sequencer: load/issue/unload, timeout, wait, abort and reset.
module tb_pcpi_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic        nib_valid;
  logic [3:0]  nib_data;
  logic        nib_ready;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wait;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        res_valid;
  logic [3:0]  res_nib;
  logic        res_ready;
  logic        done;
  logic        err_timeout;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pcpi_nibble_sequencer #(.NIBBLES(8), .TIMEOUT(16), .TMR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .nib_valid(nib_valid), .nib_data(nib_data), .nib_ready(nib_ready),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_ready(pcpi_ready), .pcpi_wait(pcpi_wait), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .res_valid(res_valid), .res_nib(res_nib), .res_ready(res_ready),
    .done(done), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_from(input logic [31:0] insn, input int start);
    for (int i = start; i < 8; i++) begin
      check("load_nib_ready", nib_ready, 1);
      nib_valid = 1'b1;
      nib_data  = insn[4*i +: 4];
      tick();
      if (i < 7) check("load_valid_early", pcpi_valid, 0);
    end
    nib_valid = 1'b0;
    check("issue_valid", pcpi_valid, 1);
    check("issue_insn", pcpi_insn, insn);
    check("issue_nib_ready", nib_ready, 0);
  endtask

  task automatic drain(input logic [31:0] word);
    logic [31:0] w;
    w = word;
    res_ready = 1'b0;
    tick();
    check("unload_stall_hold", res_nib, w[3:0]);
    for (int i = 0; i < 8; i++) begin
      check("unload_valid", res_valid, 1);
      check("unload_nib", res_nib, w[4*i +: 4]);
      check("unload_no_done", done, 0);
      res_ready = 1'b1;
      tick();
    end
    res_ready = 1'b0;
    check("unload_end_valid", res_valid, 0);
    check("unload_done", done, 1);
    tick();
    check("unload_done_pulse", done, 0);
    check("unload_nib_ready", nib_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; abort = 1'b0; nib_valid = 1'b0; nib_data = 4'h0;
    pcpi_ready = 1'b0; pcpi_wait = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'h0;
    res_ready = 1'b0;

    // reset values
    #12;
    check("rst_nib_ready", nib_ready, 0);
    check("rst_pcpi_valid", pcpi_valid, 0);
    check("rst_insn", pcpi_insn, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_nib", res_nib, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rel_nib_ready_low", nib_ready, 0);
    tick();
    check("rel_nib_ready_high", nib_ready, 1);

    // 1/2: load 1..8, respond after 3 cycles with a write
    load_from(32'h87654321, 0);
    repeat (3) tick();
    check("t2_still_valid", pcpi_valid, 1);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEADBEEF;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    check("t2_valid_drop", pcpi_valid, 0);
    check("t2_res_valid", res_valid, 1);
    check("t2_state_unload", dbg_state, 2);
    drain(32'hDEADBEEF);

    // 3: ready without write
    load_from(32'h12345678, 0);
    pcpi_ready = 1'b1; pcpi_wr = 1'b0;
    tick();
    pcpi_ready = 1'b0;
    check("t3_valid_drop", pcpi_valid, 0);
    check("t3_done", done, 1);
    check("t3_no_res", res_valid, 0);
    check("t3_nib_ready", nib_ready, 1);
    tick();
    check("t3_done_pulse", done, 0);
    check("t3_no_res_after", res_valid, 0);
    check("t3_nib_ready_after", nib_ready, 1);

    // 4: timeout after exactly 16 silent cycles
    load_from(32'hCAFEF00D, 0);
    repeat (15) tick();
    check("t4_valid_at_15", pcpi_valid, 1);
    check("t4_err_at_15", err_timeout, 0);
    tick();
    check("t4_valid_drop", pcpi_valid, 0);
    check("t4_err_set", err_timeout, 1);
    check("t4_no_done", done, 0);
    check("t4_state_load", dbg_state, 0);
    tick();
    check("t4_err_sticky", err_timeout, 1);
    check("t4_insn_hold", pcpi_insn, 32'hCAFEF00D);

    // first nibble clears err, then long wait, then ready on the expiry cycle
    check("t4_nib_ready", nib_ready, 1);
    nib_valid = 1'b1; nib_data = 4'hF;
    tick();
    check("t4_err_cleared", err_timeout, 0);
    load_from(32'h13579BDF, 1);
    pcpi_wait = 1'b1;
    repeat (40) tick();
    check("t4_wait_valid", pcpi_valid, 1);
    check("t4_wait_err", err_timeout, 0);
    pcpi_wait = 1'b0;
    repeat (15) tick();
    check("t5_valid_at_15", pcpi_valid, 1);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h01234567;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    check("t5_res_valid", res_valid, 1);
    check("t5_err", err_timeout, 0);
    check("t5_valid_drop", pcpi_valid, 0);
    check("t5_res_nib0", res_nib, 4'h7);
    drain(32'h01234567);

    // abort on the 5th nibble
    for (int i = 0; i < 4; i++) begin
      nib_valid = 1'b1; nib_data = 4'h9;
      tick();
    end
    abort = 1'b1; nib_data = 4'h9;
    tick();
    abort = 1'b0; nib_valid = 1'b0;
    check("ab_nib_ready", nib_ready, 1);
    check("ab_valid", pcpi_valid, 0);
    check("ab_state", dbg_state, 0);
    load_from(32'h2468ACE0, 0);

    // abort beats pcpi_ready in the same cycle
    abort = 1'b1; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hFFFFFFFF;
    tick();
    abort = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    check("abr_res_valid", res_valid, 0);
    check("abr_done", done, 0);
    check("abr_valid", pcpi_valid, 0);
    check("abr_state", dbg_state, 0);
    tick();
    check("abr_done_later", done, 0);
    check("abr_nib_ready", nib_ready, 1);

    // 6: async reset mid-unload with the receiver stalled
    load_from(32'h0F1E2D3C, 0);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hA5A55A5A;
    tick();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    check("t6_res_valid", res_valid, 1);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_res_valid", res_valid, 0);
    check("t6_async_res_nib", res_nib, 0);
    check("t6_async_nib_ready", nib_ready, 0);
    check("t6_async_insn", pcpi_insn, 0);
    check("t6_async_state", dbg_state, 0);
    #2;
    rst_n = 1'b1;
    check("t6_rel_nib_ready_low", nib_ready, 0);
    tick();
    check("t6_rel_nib_ready", nib_ready, 1);
    check("t6_rel_res_valid", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
